// File: rtl/pio_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pio_cond_pkg
//  Brief    : Shared constants and types for the PIO input conditioning block.
//  Revision : 1.0 - initial release
// ============================================================================
package pio_cond_pkg;

    localparam int NUM_BTN = 2;
    localparam int NUM_SW  = 4;
    localparam int NUM_CH  = NUM_BTN + NUM_SW;

    // 20 ms of stable input at a 50 MHz system clock
    localparam int DEBOUNCE_CYCLES_50MHZ = 1000000;

    localparam int BTN0 = 0;
    localparam int BTN1 = 1;
    localparam int SW0  = 2;
    localparam int SW1  = 3;
    localparam int SW2  = 4;
    localparam int SW3  = 5;

    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : pio_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Brief    : One-bit synchroniser, stability counter, level register and
//             rise/fall pulse generator.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import pio_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int   CNT_W           = 20,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             w_accept;

    // Acceptance strobe is also used by the top level to register its
    // aggregate outputs in the same cycle as the pulses.
    assign w_accept = (r_s2 != r_level) && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= RESET_LEVEL;
            r_s2    <= RESET_LEVEL;
            r_level <= RESET_LEVEL;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_s2;
                r_cnt   <= '0;
                r_rise  <= r_s2;
                r_fall  <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/pio_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : pio_input_debounce
//  Brief    : Debounces button/DIP-switch inputs ahead of the HPS PIOs and
//             reports edges plus an aggregate transition count.
//  Revision : 1.0 - initial release
// ============================================================================
module pio_input_debounce #(
    parameter int                 NUM_CH          = pio_cond_pkg::NUM_CH,
    parameter int                 DEBOUNCE_CYCLES = pio_cond_pkg::DEBOUNCE_CYCLES_50MHZ,
    parameter int                 CNT_W           = 20,
    parameter logic [NUM_CH-1:0]  RESET_LEVEL     = 6'b000011,
    parameter int                 EVT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_change,
    output logic [EVT_W-1:0]  evt_count,
    input  logic              evt_clr
);

    import pio_cond_pkg::*;

    logic [NUM_CH-1:0] w_accept;
    logic [EVT_W-1:0]  w_accept_cnt;
    logic              r_any_change;
    logic [EVT_W-1:0]  r_evt_count;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_LEVEL     (RESET_LEVEL[g])
        ) u_ch (
            .clk      (clk),
            .rst      (reset),
            .i_raw    (raw_in[g]),
            .o_level  (db_out[g]),
            .o_rise   (rise_pulse[g]),
            .o_fall   (fall_pulse[g]),
            .o_accept (w_accept[g])
        );
    end

    always_comb begin
        w_accept_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_accept_cnt = w_accept_cnt + EVT_W'(w_accept[i]);
        end
    end

    // A clear coincident with acceptances drops those events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_change <= 1'b0;
            r_evt_count  <= '0;
        end else begin
            r_any_change <= |w_accept;
            if (evt_clr) begin
                r_evt_count <= '0;
            end else begin
                r_evt_count <= r_evt_count + w_accept_cnt;
            end
        end
    end

    assign any_change = r_any_change;
    assign evt_count  = r_evt_count;

endmodule : pio_input_debounce
`default_nettype wire

// File: doc/pio_input_debounce.md
Name: pio_input_debounce

Overview:
- Conditions raw board inputs (2 push-buttons, 4 DIP switches) before they reach the button and DIP-switch PIO inputs of the HPS system.
- Per channel it does three things: 2-flop synchronisation, counter-based debounce, and edge detection.
- Emits clean levels, one-cycle rise/fall pulses and an aggregate event count for a status register.
- Sits directly upstream of the system's button_pio/dipsw_pio external connections.

Parameters:
- NUM_CH, 6: number of input channels. Bits [1:0] are buttons, [5:2] are DIP switches.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz). Legal range is 2..2^CNT_W-1.
- CNT_W, 20: width of each per-channel stability counter.
- RESET_LEVEL, 6'b000011: reset value of the sync flops and of db_out. Buttons idle high (active-low); switches reset low.
- EVT_W, 16: width of the event counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- raw_in  in  NUM_CH  asynchronous board inputs.
- db_out  out  NUM_CH  debounced levels; bits [1:0] go to the button PIO, bits [5:2] to the dipsw PIO.
- rise_pulse  out  NUM_CH  one-cycle pulse when db_out bit goes 0->1.
- fall_pulse  out  NUM_CH  one-cycle pulse when db_out bit goes 1->0.
- any_change  out  1  OR of all rise_pulse and fall_pulse bits, registered with them (same cycle).
- evt_count  out  EVT_W  count of accepted transitions, all channels. Wraps modulo 2^EVT_W.
- evt_clr  in  1  synchronous clear of evt_count.

Behaviour:
- Reset (clk edge with reset=1):
  - s1, s2 and db_out are set to RESET_LEVEL.
  - Counters are set to 0.
  - rise_pulse, fall_pulse, any_change and evt_count are set to 0.
  - Reset takes priority over all other activity. A debounce in progress is discarded with no pulse.
- Synchroniser: s1 <= raw_in; s2 <= s1. Only s2 feeds the debounce logic.
- Per channel, at each edge:
  - If s2 == db_out: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db_out <= s2, cnt <= 0, and the matching rise_pulse or fall_pulse bit is set to 1 for this cycle.
  - Else: cnt <= cnt+1.
- Accepting a level therefore takes DEBOUNCE_CYCLES consecutive edges with s2 != db_out.
- Latency: a step on raw_in that is set up before edge E appears on db_out after edge E+1+DEBOUNCE_CYCLES. rise_pulse/fall_pulse assert in the same cycle as the db_out update.
- Glitch rejection: any return of s2 to db_out before the count completes resets cnt to 0. No output change and no pulse result.
- Pulses are registered and deassert on the next edge unless a new transition is accepted.
- rise_pulse and fall_pulse are never both 1 for the same bit.
- evt_count, at each edge:
  - If evt_clr: evt_count <= 0.
  - Else: evt_count <= evt_count + popcount(rise_pulse | fall_pulse) of the transitions accepted at this edge. Multiple channels accepting at the same edge add their full count.
  - If evt_clr and acceptances occur at the same edge, the clear wins and those events are dropped.
  - Wraps to 0 past 2^EVT_W-1.
- Counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Channels are fully independent: no shared state except evt_count.

Decomposition:
- Shared package pio_cond_pkg holds:
  - constant NUM_BTN = 2 and NUM_SW = 4;
  - default DEBOUNCE_CYCLES for 50 MHz;
  - channel index constants BTN0, BTN1, SW0..SW3;
  - typedef ch_vec_t logic [NUM_CH-1:0].
- One sub-module, debounce_channel: sync flops, counter, level register and rise/fall pulse for one bit. Instantiated NUM_CH times by generate.
- The top level adds any_change and the evt_count adder/popcount.

Test Plan:
All directed tests use DEBOUNCE_CYCLES=4, CNT_W=3, NUM_CH=6, RESET_LEVEL=6'b000011.
- Reset: hold reset 3 cycles with raw_in=6'b111100 -> db_out=6'b000011, all pulses 0, evt_count=0; after release, db_out stays 6'b000011 for 5 edges.
- Clean step: raw_in[2] 0->1 before edge E -> db_out[2]=1 and rise_pulse[2]=1 after edge E+5, for exactly one cycle; evt_count=1; any_change=1 in the same cycle.
- Glitch: raw_in[0] low for 3 cycles then back high -> db_out[0] stays 1, fall_pulse[0] never asserts, evt_count unchanged.
- Simultaneous: raw_in[1:0] 11->00 and raw_in[5] 0->1 at the same edge -> fall_pulse=6'b000011 and rise_pulse=6'b100000 in one cycle; evt_count increases by 3.
- Reset mid-debounce: step raw_in[3], assert reset after 3 edges -> no pulse, db_out[3]=0; after release with raw_in[3] still 1, acceptance takes a full 6 edges from release.
- Clear and wrap: preload via 2^16-1 accepted events (or force), then one more event -> evt_count=0; evt_clr coincident with an acceptance -> evt_count=0 next cycle.
